// File: rtl/vnu_serial_if.sv
// Handshake bundle between the LDPC variable-node unit and its neighbours:
// channel LLR and check messages flow in, and extrinsic q messages flow out.
interface vnu_serial_if #(
    parameter int data_w = 8
);
    logic                     llr_valid;
    logic signed [data_w-1:0] llr;
    logic                     r_valid;
    logic signed [data_w-1:0] r;
    logic                     in_ready;
    logic                     q_valid;
    logic                     q_ready;
    logic signed [data_w-1:0] q;
    logic                     q_last;
    logic                     hard;

    modport master (
        output llr_valid, llr, r_valid, r, q_ready,
        input  in_ready, q_valid, q, q_last, hard
    );

    modport slave (
        input  llr_valid, llr, r_valid, r, q_ready,
        output in_ready, q_valid, q, q_last, hard
    );
endinterface

// File: rtl/vnu_serial.sv
// Serial LDPC variable-node unit: sums the channel LLR with DV check messages, then
// emits DV extrinsic messages (total minus own input). VNU_SAT_EN selects saturation over wrap.
module vnu_serial #(
    parameter int data_w = 8,
    parameter int DV     = 3,
    parameter int ACC_W  = data_w + 4
) (
    input  logic           clk,
    input  logic           rst,
    vnu_serial_if.slave    vnu
);
    localparam int CNT_W = (DV > 1) ? $clog2(DV) : 1;
    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((2 ** (data_w - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Q_MIN = -Q_MAX;

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t                   state_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic signed [data_w-1:0] msg_buf_reg [DV];
    logic                     in_ready_reg;
    logic                     q_valid_reg;
    logic signed [data_w-1:0] q_reg;
    logic                     q_last_reg;
    logic                     hard_reg;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [data_w-1:0] v);
        return {{(ACC_W - data_w){v[data_w-1]}}, v};
    endfunction

    function automatic logic signed [data_w-1:0] sat(input logic signed [ACC_W-1:0] v);
`ifdef VNU_SAT_EN
        if (v > Q_MAX)
            return Q_MAX[data_w-1:0];
        else if (v < Q_MIN)
            return Q_MIN[data_w-1:0];
        else
            return v[data_w-1:0];
`else
        return v[data_w-1:0];
`endif
    endfunction

    logic                     r_take;
    logic                     last_r;
    logic [CNT_W-1:0]         cnt_next;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [DV-1:0]            buf_we;
    logic [CNT_W-1:0]         idx_next;
    logic signed [ACC_W-1:0]  tot_next;
    logic signed [data_w-1:0] q_next;

    assign r_take   = (state_reg == ACCUM) && vnu.r_valid;
    assign last_r   = (cnt_reg == CNT_W'(DV - 1));
    assign cnt_next = cnt_reg + 1'b1;
    assign acc_sum  = acc_reg + sext(vnu.r);

    genvar gi;
    generate
        for (gi = 0; gi < DV; gi++) begin : g_buf_we
            assign buf_we[gi] = r_take && (cnt_reg == CNT_W'(gi));
        end
    endgenerate

    // q is precomputed one cycle early so the outputs leave straight from flops:
    // entering EMIT uses the fresh sum and entry 0, otherwise the next entry.
    always_comb begin
        idx_next = '0;
        tot_next = acc_sum;
        if (state_reg == EMIT) begin
            tot_next = acc_reg;
            if (!q_last_reg)
                idx_next = cnt_next;
        end
        q_next = sat(tot_next - sext(msg_buf_reg[idx_next]));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DV; i++)
                msg_buf_reg[i] <= '0;
        end else begin
            for (int i = 0; i < DV; i++)
                if (buf_we[i])
                    msg_buf_reg[i] <= vnu.r;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b1;
            q_valid_reg  <= 1'b0;
            q_reg        <= '0;
            q_last_reg   <= 1'b0;
            hard_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (vnu.llr_valid) begin
                        acc_reg   <= sext(vnu.llr);
                        cnt_reg   <= '0;
                        state_reg <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (vnu.r_valid) begin
                        acc_reg <= acc_sum;
                        if (last_r) begin
                            state_reg    <= EMIT;
                            cnt_reg      <= '0;
                            in_ready_reg <= 1'b0;
                            q_valid_reg  <= 1'b1;
                            q_reg        <= q_next;
                            q_last_reg   <= 1'b0;
                            hard_reg     <= acc_sum[ACC_W-1];
                        end else begin
                            cnt_reg <= cnt_next;
                        end
                    end
                end
                EMIT: begin
                    if (vnu.q_ready) begin
                        if (q_last_reg) begin
                            state_reg    <= IDLE;
                            cnt_reg      <= '0;
                            in_ready_reg <= 1'b1;
                            q_valid_reg  <= 1'b0;
                            q_reg        <= '0;
                            q_last_reg   <= 1'b0;
                            hard_reg     <= 1'b0;
                        end else begin
                            cnt_reg    <= cnt_next;
                            q_reg      <= q_next;
                            q_last_reg <= (cnt_next == CNT_W'(DV - 1));
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign vnu.in_ready = in_ready_reg;
    assign vnu.q_valid  = q_valid_reg;
    assign vnu.q        = q_reg;
    assign vnu.q_last   = q_last_reg;
    assign vnu.hard     = hard_reg;
endmodule

// File: tb/tb_vnu_serial.sv
// Directed bench for vnu_serial (data_w=8, DV=3): basic, negative, overflow,
// backpressure, input-gap and mid-operation reset scenarios.
module tb_vnu_serial;
    localparam int data_w = 8;
    localparam int DV     = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vnu_serial_if #(.data_w(data_w)) vif ();

    vnu_serial #(.data_w(data_w), .DV(DV)) dut (
        .clk (clk),
        .rst (rst),
        .vnu (vif.slave)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_llr(input int v);
        chk("llr in_ready", vif.in_ready, 1);
        vif.llr_valid = 1'b1;
        vif.llr       = data_w'(v);
        tick();
        vif.llr_valid = 1'b0;
    endtask

    task automatic send_r(input int v);
        chk("r in_ready", vif.in_ready, 1);
        vif.r_valid = 1'b1;
        vif.r       = data_w'(v);
        tick();
        vif.r_valid = 1'b0;
    endtask

    // Optional gaps insert idle cycles with a stray llr_valid that ACCUM must ignore.
    task automatic feed(input int l, input int r0, input int r1, input int r2, input bit gaps);
        send_llr(l);
        if (gaps) begin
            vif.llr_valid = 1'b1;
            vif.llr       = data_w'(-77);
            tick();
            vif.llr_valid = 1'b0;
            chk("gap in_ready", vif.in_ready, 1);
        end
        send_r(r0);
        if (gaps) begin
            tick();
            tick();
            chk("gap q_valid", vif.q_valid, 0);
        end
        send_r(r1);
        chk("pre-last q_valid", vif.q_valid, 0);
        if (gaps)
            tick();
        send_r(r2);
    endtask

    task automatic expect_node(input string name, input int e0, input int e1, input int e2,
                               input int eh, input int stall_idx, input int stall_n, input bit pulse);
        int e[3];
        e = '{e0, e1, e2};
        for (int i = 0; i < DV; i++) begin
            chk($sformatf("%s q%0d valid", name, i), vif.q_valid, 1);
            chk($sformatf("%s q%0d value", name, i), vif.q, e[i]);
            chk($sformatf("%s q%0d last", name, i), vif.q_last, (i == DV - 1) ? 1 : 0);
            chk($sformatf("%s q%0d hard", name, i), vif.hard, eh);
            chk($sformatf("%s q%0d in_ready", name, i), vif.in_ready, 0);
            if (i == stall_idx) begin
                vif.q_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    chk($sformatf("%s stall%0d value", name, s), vif.q, e[i]);
                    chk($sformatf("%s stall%0d valid", name, s), vif.q_valid, 1);
                    chk($sformatf("%s stall%0d last", name, s), vif.q_last, 0);
                end
            end
            vif.q_ready = 1'b1;
            if (pulse) begin
                vif.llr_valid = 1'b1;
                vif.llr       = data_w'(50);
                vif.r_valid   = 1'b1;
                vif.r         = data_w'(99);
            end
            $display("%s: q[%0d]=%0d last=%0d hard=%0d", name, i, vif.q, vif.q_last, vif.hard);
            tick();
            vif.llr_valid = 1'b0;
            vif.r_valid   = 1'b0;
        end
        chk({name, " done q_valid"}, vif.q_valid, 0);
        chk({name, " done q"}, vif.q, 0);
        chk({name, " done q_last"}, vif.q_last, 0);
        chk({name, " done hard"}, vif.hard, 0);
        chk({name, " done in_ready"}, vif.in_ready, 1);
    endtask

    initial begin
        vif.llr_valid = 1'b0;
        vif.llr       = '0;
        vif.r_valid   = 1'b0;
        vif.r         = '0;
        vif.q_ready   = 1'b1;

        tick();
        tick();
        chk("reset q_valid", vif.q_valid, 0);
        chk("reset q", vif.q, 0);
        chk("reset q_last", vif.q_last, 0);
        chk("reset hard", vif.hard, 0);
        rst = 1'b1;
        tick();
        chk("release in_ready", vif.in_ready, 1);
        chk("release q_valid", vif.q_valid, 0);

        // r while IDLE must not start or corrupt a node
        vif.r_valid = 1'b1;
        vif.r       = data_w'(100);
        tick();
        vif.r_valid = 1'b0;
        chk("idle r ignored q_valid", vif.q_valid, 0);

        feed(10, 5, -3, 7, 1'b0);
        expect_node("basic", 14, 22, 12, 0, -1, 0, 1'b0);

        feed(-20, -1, -1, -1, 1'b0);
        expect_node("negative", -22, -22, -22, 1, -1, 0, 1'b0);

        feed(100, 100, 100, -5, 1'b0);
`ifdef VNU_SAT_EN
        expect_node("overflow", 127, 127, 127, 0, -1, 0, 1'b0);
`else
        expect_node("overflow", -61, -61, 44, 0, -1, 0, 1'b0);
`endif

        feed(10, 5, -3, 7, 1'b0);
        expect_node("backpressure", 14, 22, 12, 0, 1, 3, 1'b0);

        feed(10, 5, -3, 7, 1'b1);
        expect_node("gaps", 14, 22, 12, 0, -1, 0, 1'b1);

        send_llr(10);
        send_r(5);
        send_r(-3);
        rst = 1'b0;
        #2;
        chk("midreset q_valid", vif.q_valid, 0);
        chk("midreset q", vif.q, 0);
        chk("midreset q_last", vif.q_last, 0);
        chk("midreset hard", vif.hard, 0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post-reset idle%0d q_valid", k), vif.q_valid, 0);
        end
        feed(10, 5, -3, 7, 1'b0);
        expect_node("after-reset", 14, 22, 12, 0, -1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vnu_serial.md
VNU_SERIAL -- requirements
Module: vnu_serial

Interface
REQ-001 SHALL have parameter data_w, default 8: width of the two's-complement LLR, r and q messages.
REQ-002 SHALL have parameter DV, default 3: variable-node degree, the number of check messages per node, legal range 2..8.
REQ-003 SHALL have parameter ACC_W, default data_w+4: internal accumulator width.
REQ-004 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port llr_valid, input, 1 bit: channel LLR present.
REQ-007 SHALL have port llr, input, data_w bits: signed channel LLR.
REQ-008 SHALL have port r_valid, input, 1 bit: check-node message present.
REQ-009 SHALL have port r, input, data_w bits: signed check-to-variable message, the output of the check node unit.
REQ-010 SHALL have port in_ready, output, 1 bit: block accepts llr or r this cycle.
REQ-011 SHALL have port q_valid, output, 1 bit: outgoing variable-to-check message valid.
REQ-012 SHALL have port q_ready, input, 1 bit: consumer accepts q.
REQ-013 SHALL have port q, output, data_w bits: signed extrinsic message.
REQ-014 SHALL have port q_last, output, 1 bit: current q is message DV-1.
REQ-015 SHALL have port hard, output, 1 bit: hard decision, 1 when the total is negative; valid while q_valid=1.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM and EMIT; IDLE is the reset state.
REQ-017 IDLE behaviour SHALL be:
- in_ready=1.
- On llr_valid, acc is loaded with sign-extended llr, cnt is cleared to 0, and the FSM goes to ACCUM.
- r_valid is ignored.
REQ-018 ACCUM behaviour SHALL be:
- in_ready=1.
- On r_valid, r is stored in buf[cnt], acc is updated to acc+sext(r), and cnt increments.
- On the DV-th accepted r, the FSM goes to EMIT and cnt clears.
- llr_valid is ignored.
REQ-019 EMIT behaviour SHALL be:
- in_ready=0 and q_valid=1.
- q = sat(acc - buf[cnt]).
- q_last = (cnt==DV-1).
- hard = acc[ACC_W-1].
REQ-020 In EMIT, a transfer SHALL occur on q_valid&&q_ready; cnt then increments, and after the transfer with q_last=1 the FSM returns to IDLE.
REQ-021 While q_ready=0, q, q_last and hard SHALL remain stable.
REQ-022 q_valid SHALL first assert in the cycle after the DV-th r is accepted (latency 1), and there SHALL be no bubble between consecutive q when q_ready=1.
REQ-023 A new llr SHALL be acceptable in the cycle after the last q transfer; throughput is 1+2*DV cycles per node.
REQ-024 The accumulation SHALL never overflow ACC_W for DV≤8.
REQ-025 Subtraction SHALL be performed at ACC_W before conversion to data_w.
REQ-026 q, q_last and hard SHALL be driven to 0 whenever q_valid=0.

Reset
REQ-027 On rst=0 (asynchronous), the block SHALL:
- enter IDLE;
- clear acc, cnt and all buf entries to 0;
- drive in_ready=1 after reset release, and q_valid=0, q=0, q_last=0 and hard=0.
REQ-028 A reset asserted mid-ACCUM or mid-EMIT SHALL discard the partial node; no q is emitted for it after release.

Configuration
REQ-029 Macro VNU_SAT_EN SHALL select the conversion behaviour:
- Defined: sat() clamps to [-(2^(data_w-1)-1), +(2^(data_w-1)-1)], a symmetric range, so -128 is never produced at data_w=8.
- Undefined: sat() is a plain truncation to the low data_w bits (two's-complement wrap).

Verification (data_w=8, DV=3)
REQ-030 Basic node: llr=10, r=5,-3,7 back-to-back, q_ready=1 -> q=14,22,12; hard=0; q_last on the third q; q_valid one cycle after r=7 is accepted.
REQ-031 Negative node: llr=-20, r=-1,-1,-1 -> q=-22,-22,-22; hard=1.
REQ-032 Overflow: llr=100, r=100,100,-5 -> with VNU_SAT_EN, q=127,127,127; without it, q=-61,-61,44.
REQ-033 Backpressure: basic node with q_ready low for 3 cycles at the second q -> q holds 22, and q_valid stays 1 throughout.
REQ-034 Input gaps: r_valid deasserted between messages, and llr_valid/r_valid pulsed during EMIT -> in_ready=0 and the pulses are ignored; results are identical to REQ-030.
REQ-035 Reset mid-operation: rst=0 after two r have been accepted, then a fresh basic node is applied -> the only q emitted are 14,22,12, and all outputs are 0 during reset.
